cpu_step_controller: RTL

Sequences the single-cycle computer on the board: run, single-step, halt and breakpoint control, plus a stretched CPU reset.
- Sits between the button debouncer and the computer, which is clocked from the 100 MHz clock and gated by `cpu_ce`.
- Replaces clocking the CPU directly from a button.
- Exposes state and a retired-instruction count for the seven-segment display.

---
 rtl/cpu_step_controller.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_step_controller.sv
// -----------------------------------------------------------------------------
// cpu_step_controller
//
// Run / single-step / halt / breakpoint sequencer for the single-cycle CPU on
// the board. The CPU runs from the 100 MHz system clock and advances only on
// cycles where cpu_ce is high. This block also stretches a CPU reset over
// RST_CYCLES clocks.
//
// Optional feature: define CPU_STEP_CTRL_BREAKPOINT_EN to build the PC
// breakpoint comparator and the BREAK state. Without it, bp_en, bp_addr and pc
// are ignored, BREAK cannot be reached and bp_hit is constant 0.
//
// Parameters
//   RUN_DIV     clk cycles between cpu_ce pulses in RUN (>= 2)
//   RST_CYCLES  cycles cpu_reset is held per reset sequence (>= 1)
//   CNT_W       width of instr_count
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high controller reset
//   step_btn     in   debounced step button (level, rising edge used)
//   run_sw       in   1 = free-run request, 0 = halt request
//   soft_rst     in   debounced CPU-reset button (level, rising edge used)
//   pc           in   current fetch PC from the CPU
//   bp_en        in   breakpoint enable
//   bp_addr      in   breakpoint PC
//   cpu_ce       out  one-cycle CPU clock enable
//   cpu_reset    out  active-high reset to the CPU
//   state_o      out  0=RST 1=HALT 2=STEP 3=RUN 4=BREAK
//   bp_hit       out  high while in BREAK
//   instr_count  out  cpu_ce pulses since the last reset sequence (wraps)
// -----------------------------------------------------------------------------
module cpu_step_controller #(
  parameter int RUN_DIV    = 1000000,
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_btn,
  input  logic             run_sw,
  input  logic             soft_rst,
  input  logic [31:0]      pc,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  output logic             cpu_ce,
  output logic             cpu_reset,
  output logic [2:0]       state_o,
  output logic             bp_hit,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] ST_RST   = 3'd0;
  localparam logic [2:0] ST_HALT  = 3'd1;
  localparam logic [2:0] ST_STEP  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
  localparam logic [2:0] ST_BREAK = 3'd4;
`endif

  localparam int DIV_W = $clog2(RUN_DIV);
  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

  // Registered state and outputs
  logic [2:0]       r_state;
  logic [DIV_W-1:0] r_div;
  logic [RST_W-1:0] r_rst_cnt;
  logic             r_step_d;
  logic             r_soft_d;
  logic             r_cpu_ce;
  logic             r_cpu_reset;
  logic [CNT_W-1:0] r_instr_count;

  // Next-state values
  logic [2:0]       w_next_state;
  logic [DIV_W-1:0] w_div_next;
  logic [RST_W-1:0] w_rst_cnt_next;
  logic             w_pulse;
  logic             w_step_edge;
  logic             w_soft_edge;

`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
  logic r_skip_bp;
  logic r_bp_hit;
  logic w_skip_next;
  logic w_bp_match;

  // skip_bp lets a RUN started on the breakpoint PC execute that instruction
  // before the comparator is allowed to stop the CPU.
  assign w_bp_match = bp_en && (pc == bp_addr) && !r_skip_bp;
  assign bp_hit     = r_bp_hit;
`else
  logic w_unused_bp;

  assign w_unused_bp = ^{bp_en, pc, bp_addr};
  assign bp_hit      = 1'b0;
`endif

  assign w_step_edge = step_btn & ~r_step_d;
  assign w_soft_edge = soft_rst & ~r_soft_d;

  assign cpu_ce      = r_cpu_ce;
  assign cpu_reset   = r_cpu_reset;
  assign state_o     = r_state;
  assign instr_count = r_instr_count;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    w_next_state   = r_state;
    w_div_next     = r_div;
    w_rst_cnt_next = r_rst_cnt;
    w_pulse        = 1'b0;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
    w_skip_next    = r_skip_bp;
`endif

    if (w_soft_edge && (r_state != ST_RST)) begin
      // A CPU-reset press outranks step, run and a due pulse.
      w_next_state   = ST_RST;
      w_div_next     = '0;
      w_rst_cnt_next = '0;
    end else begin
      case (r_state)
        ST_RST: begin
          if (r_rst_cnt == RST_LAST) begin
            w_next_state = ST_HALT;
          end else begin
            w_rst_cnt_next = r_rst_cnt + 1'b1;
          end
        end

        ST_HALT: begin
          // run_sw wins over a step edge arriving on the same cycle.
          if (run_sw) begin
            w_next_state = ST_RUN;
            w_div_next   = '0;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
            w_skip_next  = 1'b1;
`endif
          end else if (w_step_edge) begin
            w_next_state = ST_STEP;
            w_pulse      = 1'b1;
          end
        end

        ST_STEP: begin
          w_next_state = ST_HALT;
        end

        ST_RUN: begin
          if (!run_sw) begin
            w_next_state = ST_HALT;
            w_div_next   = '0;
          end else if (r_div == DIV_LAST) begin
            w_div_next = '0;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
            // Stop before the breakpointed instruction executes.
            if (w_bp_match) begin
              w_next_state = ST_BREAK;
            end else begin
              w_pulse     = 1'b1;
              w_skip_next = 1'b0;
            end
`else
            w_pulse = 1'b1;
`endif
          end else begin
            w_div_next = r_div + 1'b1;
          end
        end

`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
        ST_BREAK: begin
          if (!run_sw) begin
            w_next_state = ST_HALT;
          end else if (w_step_edge) begin
            w_next_state = ST_STEP;
            w_pulse      = 1'b1;
          end
        end
`endif

        default: begin
          // Unused encodings fall back into a full reset sequence.
          w_next_state   = ST_RST;
          w_div_next     = '0;
          w_rst_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    // The edge-detect registers track the buttons through reset too, so a
    // button already held when reset drops is not seen as a press.
    r_step_d <= step_btn;
    r_soft_d <= soft_rst;

    if (reset) begin
      r_state       <= ST_RST;
      r_div         <= '0;
      r_rst_cnt     <= '0;
      r_cpu_ce      <= 1'b0;
      r_cpu_reset   <= 1'b1;
      r_instr_count <= '0;
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
      r_skip_bp     <= 1'b0;
      r_bp_hit      <= 1'b0;
`endif
    end else begin
      r_state     <= w_next_state;
      r_div       <= w_div_next;
      r_rst_cnt   <= w_rst_cnt_next;
      r_cpu_ce    <= w_pulse;
      r_cpu_reset <= (w_next_state == ST_RST);
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
      r_skip_bp   <= w_skip_next;
      r_bp_hit    <= (w_next_state == ST_BREAK);
`endif
      if (w_next_state == ST_RST) begin
        r_instr_count <= '0;
      end else if (w_pulse) begin
        r_instr_count <= r_instr_count + 1'b1;
      end
    end
  end

endmodule
